spi_mem_ctrl: RTL

//  Responder side of the control unit's spi_executing/spi_done handshake.

---
 rtl/spi_mem_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: serves one ROM fetch, RAM read or RAM write per
// spi_executing request. The ROM and RAM share sclk/mosi/miso and have separate
// chip selects.
module spi_mem_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_executing,
    output logic        spi_done,
    input  logic        rom_read,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        rom_cs_n,
    output logic        ram_cs_n
);

    localparam int ADDR_W     = 8 * ADDR_BYTES;
    localparam int FRAME_BITS = 16 + ADDR_W;
    localparam int DIV_W      = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CMD_END  = CNT_W'(8);
    localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(8 + ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_FINISH
    } state_t;

    state_t                  r_state, r_state_next;
    logic [DIV_W-1:0]        r_div, r_div_next;
    logic [CNT_W-1:0]        r_bit, r_bit_next;
    logic [FRAME_BITS-1:0]   r_shift, r_shift_next;
    logic [7:0]              r_rx, r_rx_next;
    logic                    r_is_read, r_is_read_next;
    logic                    r_done, r_done_next;
    logic [7:0]              r_data_out, r_data_out_next;
    logic                    r_sclk, r_sclk_next;
    logic                    r_rom_cs_n, r_rom_cs_n_next;
    logic                    r_ram_cs_n, r_ram_cs_n_next;

    logic                    w_any_op;
    logic [7:0]              w_cmd;
    logic [FRAME_BITS-1:0]   w_frame;
    logic [CNT_W-1:0]        w_bit_inc;

    // Whole frame is built at accept time; the address is zero-extended so
    // the upper address bytes go out as 0.
    assign w_any_op  = ram_write | ram_read | rom_read;
    assign w_cmd     = ram_write ? 8'h02 : 8'h03;
    assign w_frame   = {w_cmd, ADDR_W'(addr), (ram_write ? data_in : 8'h00)};
    assign w_bit_inc = r_bit + CNT_W'(1);

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        r_state_next    = r_state;
        r_div_next      = r_div;
        r_bit_next      = r_bit;
        r_shift_next    = r_shift;
        r_rx_next       = r_rx;
        r_is_read_next  = r_is_read;
        r_done_next     = r_done;
        r_data_out_next = r_data_out;
        r_sclk_next     = r_sclk;
        r_rom_cs_n_next = r_rom_cs_n;
        r_ram_cs_n_next = r_ram_cs_n;

        case (r_state)
            S_IDLE: begin
                r_done_next     = 1'b1;
                r_sclk_next     = 1'b0;
                r_rom_cs_n_next = 1'b1;
                r_ram_cs_n_next = 1'b1;
                if (spi_executing) begin
                    r_done_next = 1'b0;
                    r_div_next  = '0;
                    r_bit_next  = '0;
                    if (w_any_op) begin
                        // Priority ram_write > ram_read > rom_read; the chip
                        // select drops together with the command MSB on mosi.
                        r_state_next    = S_CMD;
                        r_shift_next    = w_frame;
                        r_is_read_next  = ~ram_write;
                        r_ram_cs_n_next = ~(ram_write | ram_read);
                        r_rom_cs_n_next = ram_write | ram_read;
                    end else begin
                        // NOP: single busy cycle, no bus activity.
                        r_state_next   = S_FINISH;
                        r_is_read_next = 1'b0;
                    end
                end
            end

            S_CMD, S_ADDR, S_DATA: begin
                if (r_div == DIV_LAST) begin
                    r_div_next  = '0;
                    r_sclk_next = 1'b0;
                    if (r_bit == BIT_LAST) begin
                        r_state_next    = S_FINISH;
                        r_shift_next    = '0;
                        r_rom_cs_n_next = 1'b1;
                        r_ram_cs_n_next = 1'b1;
                    end else begin
                        // New bit starts with sclk low; mosi moves only here.
                        r_bit_next   = w_bit_inc;
                        r_shift_next = r_shift << 1;
                        if (w_bit_inc < CMD_END)
                            r_state_next = S_CMD;
                        else if (w_bit_inc < ADDR_END)
                            r_state_next = S_ADDR;
                        else
                            r_state_next = S_DATA;
                    end
                end else begin
                    r_div_next  = r_div + DIV_W'(1);
                    r_sclk_next = (r_div >= DIV_RISE);
                    // Capture miso on the edge where sclk goes 0->1.
                    if (r_div == DIV_RISE)
                        r_rx_next = {r_rx[6:0], miso};
                end
            end

            S_FINISH: begin
                r_state_next    = S_IDLE;
                r_done_next     = 1'b1;
                r_sclk_next     = 1'b0;
                r_rom_cs_n_next = 1'b1;
                r_ram_cs_n_next = 1'b1;
                if (r_is_read)
                    r_data_out_next = r_rx;
            end

            default: begin
                r_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous abort on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_rx       <= '0;
            r_is_read  <= 1'b0;
            r_done     <= 1'b1;
            r_data_out <= '0;
            r_sclk     <= 1'b0;
            r_rom_cs_n <= 1'b1;
            r_ram_cs_n <= 1'b1;
        end else begin
            r_state    <= r_state_next;
            r_div      <= r_div_next;
            r_bit      <= r_bit_next;
            r_shift    <= r_shift_next;
            r_rx       <= r_rx_next;
            r_is_read  <= r_is_read_next;
            r_done     <= r_done_next;
            r_data_out <= r_data_out_next;
            r_sclk     <= r_sclk_next;
            r_rom_cs_n <= r_rom_cs_n_next;
            r_ram_cs_n <= r_ram_cs_n_next;
        end
    end

    // The shift register is cleared outside a frame, so its MSB is mosi directly.
    assign spi_done = r_done;
    assign data_out = r_data_out;
    assign sclk     = r_sclk;
    assign mosi     = r_shift[FRAME_BITS-1];
    assign rom_cs_n = r_rom_cs_n;
    assign ram_cs_n = r_ram_cs_n;

endmodule
